// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target.
//   i2c_slv_state_t : target protocol state machine encoding
//   ACK / NACK      : SDA level of the 9th-clock acknowledge bit
//   RW_WRITE/RW_READ: encoding of the R/W bit following the 7-bit address
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } i2c_slv_state_t;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Bus sampler for the I2C target: two-flop synchronizer on SCL and SDA,
// followed by one edge register used to detect transitions.
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   scl_i, sda_i : raw bus pins
//   sda_o        : synchronized SDA level (valid for sampling on scl_rise_o)
//   scl_rise_o   : SCL rising edge detected (one clk pulse)
//   scl_fall_o   : SCL falling edge detected (one clk pulse)
//   start_det_o  : SDA fell while SCL high
//   stop_det_o   : SDA rose while SCL high
module i2c_sync_edge
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;
  logic       scl_s;
  logic       sda_s;

  // Reset to the idle bus level (both high) so leaving reset never
  // fabricates an edge or a START/STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];

  assign sda_o       = sda_s;
  assign scl_rise_o  =  scl_s & ~scl_prev_q;
  assign scl_fall_o  = ~scl_s &  scl_prev_q;
  // SCL must be high in both samples so an SDA change near an SCL edge
  // is never mistaken for a bus condition.
  assign start_det_o = scl_s & scl_prev_q & ~sda_s &  sda_prev_q;
  assign stop_det_o  = scl_s & scl_prev_q &  sda_s & ~sda_prev_q;

endmodule

// File: rtl/i2c_slave_target.sv
// 7-bit-address I2C target with an internal byte register bank.
// A write transfer sets the register pointer with its first data byte and
// writes the following bytes at auto-incrementing addresses; a read transfer
// returns bytes from the pointer onwards, auto-incrementing.
// Ports:
//   clk, rst : system clock (>= 8x SCL), asynchronous active-high reset
//   SCL      : bus clock (input only, never stretched)
//   SDA      : open-drain data, driven only 0 or z
//   busy     : high from address match until STOP / mismatch / reset
//   wr_en    : one-clk pulse per register write, with wr_addr / wr_data
//   ptr      : current register pointer
module i2c_slave_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         MEM_DEPTH  = 16,
  localparam int        AW         = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          SCL,
  inout  wire           SDA,
  output logic          busy,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic [AW-1:0] ptr
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_sync_edge u_sync_edge (
    .clk         (clk),
    .rst         (rst),
    .scl_i       (SCL),
    .sda_i       (SDA),
    .sda_o       (sda_s),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det)
  );

  i2c_slv_state_t state_q, state_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     rx_q, rx_d;
  logic [7:0]     tx_q, tx_d;
  logic           rw_q, rw_d;
  logic           sda_oe_q, sda_oe_d;   // 1 = pull SDA low
  logic           busy_q, busy_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic           wr_en_q, wr_en_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]     wr_data_q, wr_data_d;
  logic [7:0]     rx_shift;
  logic [7:0]     mem_q [MEM_DEPTH];
  logic [7:0]     rd_byte;

  assign rx_shift = {rx_q[6:0], sda_s};
  assign rd_byte  = mem_q[ptr_q];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    // Bus conditions take priority over any bit seen in the same clk;
    // a partially shifted byte is simply abandoned.
    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;

        ST_ADDR: begin
          if (scl_rise) begin
            rx_d      = rx_shift;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (rx_shift[7:1] == SLAVE_ADDR) begin
                state_d = ST_ADDR_ACK;
                rw_d    = rx_shift[0];
                busy_d  = 1'b1;
              end else begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
              end
            end
          end
        end

        // In every ACK state sda_oe_q doubles as the phase flag: the first
        // SCL fall (end of bit 8) starts the ACK, the second ends it.
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q == RW_READ) begin
              state_d   = ST_RDATA;
              bit_cnt_d = 4'd0;
              tx_d      = rd_byte;
              sda_oe_d  = ~rd_byte[7];
              ptr_d     = ptr_q + AW'(1);
            end else begin
              state_d   = ST_PTR;
              bit_cnt_d = 4'd0;
              sda_oe_d  = 1'b0;
            end
          end
        end

        ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            rx_d      = rx_shift;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (state_q == ST_PTR) begin
                state_d = ST_PTR_ACK;
                ptr_d   = rx_shift[AW-1:0];
              end else begin
                state_d   = ST_WDATA_ACK;
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = rx_shift;
                ptr_d     = ptr_q + AW'(1);
              end
            end
          end
        end

        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              state_d   = ST_WDATA;
              bit_cnt_d = 4'd0;
              sda_oe_d  = 1'b0;
            end
          end
        end

        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d  = ST_RDATA_ACK;
              sda_oe_d = 1'b0;
            end else begin
              sda_oe_d = ~tx_q[6];
              tx_d     = {tx_q[6:0], 1'b0};
            end
          end
        end

        // A fall here can only follow a rise that did not NACK, so it is
        // the end of an ACKed 9th clock and the next byte is loaded.
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s == NACK) begin
              state_d = ST_IDLE;
            end
          end else if (scl_fall) begin
            state_d   = ST_RDATA;
            bit_cnt_d = 4'd0;
            tx_d      = rd_byte;
            sda_oe_d  = ~rd_byte[7];
            ptr_d     = ptr_q + AW'(1);
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 4'd0;
      rx_q      <= 8'd0;
      tx_q      <= 8'd0;
      rw_q      <= RW_WRITE;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'd0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      if (wr_en_d) begin
        mem_q[wr_addr_d] <= wr_data_d;
      end
    end
  end

  assign SDA     = sda_oe_q ? 1'b0 : 1'bz;
  assign busy    = busy_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign ptr     = ptr_q;

endmodule

// File: tb/tb_i2c_slave_target.sv
module tb_i2c_slave_target;

  localparam int AW = 4;
  localparam int Q  = 10;   // clk cycles per quarter SCL period

  logic          clk = 1'b0;
  logic          rst;
  logic          m_scl;
  logic          m_sda_low;
  wire           SDA;
  logic          busy;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] ptr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] wr_log_addr [$];
  logic [7:0]    wr_log_data [$];
  logic          busy_seen;
  logic          dut_drove;
  logic [7:0]    rd_buf [4];

  pullup (SDA);
  assign SDA = m_sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave_target #(.SLAVE_ADDR(7'h50), .MEM_DEPTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .SCL     (m_scl),
    .SDA     (SDA),
    .busy    (busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .ptr     (ptr)
  );

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_log_addr.push_back(wr_addr);
      wr_log_data.push_back(wr_data);
    end
    if (busy === 1'b1) busy_seen = 1'b1;
    if (SDA === 1'b0 && !m_sda_low) dut_drove = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_logs();
    wr_log_addr.delete();
    wr_log_data.delete();
    busy_seen = 1'b0;
    dut_drove = 1'b0;
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  // Works both from an idle bus and as a repeated START (SCL low).
  task automatic i2c_start();
    m_sda_low = 1'b0; wait_q();
    m_scl = 1'b1;     wait_q();
    m_sda_low = 1'b1; wait_q();
    m_scl = 1'b0;     wait_q();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wait_q();
    m_scl = 1'b1;     wait_q();
    m_sda_low = 1'b0; wait_q();
  endtask

  task automatic put_bit(input logic b);
    m_sda_low = ~b; wait_q();
    m_scl = 1'b1;   wait_q(); wait_q();
    m_scl = 1'b0;   wait_q();
  endtask

  task automatic get_bit(output logic b);
    m_sda_low = 1'b0; wait_q();
    m_scl = 1'b1;     wait_q();
    b = (SDA === 1'b0) ? 1'b0 : 1'b1;
    wait_q();
    m_scl = 1'b0;     wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack_n);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  // Pointer-set write, repeated START, read n bytes (last one NACKed), STOP.
  task automatic read_at(input string tag, input logic [7:0] p, input int n);
    logic a;
    i2c_start();
    write_byte(8'hA0, a); check_eq({tag, "_addr_w_ack"}, 32'(a), 32'(0));
    write_byte(p, a);     check_eq({tag, "_ptr_ack"}, 32'(a), 32'(0));
    i2c_start();
    write_byte(8'hA1, a); check_eq({tag, "_addr_r_ack"}, 32'(a), 32'(0));
    for (int i = 0; i < n; i++) read_byte(rd_buf[i], (i == n - 1));
    check_eq({tag, "_sda_released"}, 32'(SDA === 1'b1), 32'(1));
    check_eq({tag, "_busy_before_stop"}, 32'(busy), 32'(1));
    i2c_stop();
    wait_q();
    check_eq({tag, "_busy_after_stop"}, 32'(busy), 32'(0));
    $display("txn %s: read %0d byte(s) from ptr 0x%0h, ptr now %0d", tag, n, p, ptr);
  endtask

  initial begin
    logic a;

    rst = 1'b1; m_scl = 1'b1; m_sda_low = 1'b0;
    clear_logs();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Reset state
    check_eq("rst_busy",    32'(busy),    32'(0));
    check_eq("rst_wr_en",   32'(wr_en),   32'(0));
    check_eq("rst_ptr",     32'(ptr),     32'(0));
    check_eq("rst_wr_addr", 32'(wr_addr), 32'(0));
    check_eq("rst_wr_data", 32'(wr_data), 32'(0));
    check_eq("rst_sda_z",   32'(SDA === 1'b1), 32'(1));

    // 1: write 0xA5, 0x5A at pointer 3
    clear_logs();
    i2c_start();
    write_byte(8'hA0, a); check_eq("w1_addr_ack", 32'(a), 32'(0));
    write_byte(8'h03, a); check_eq("w1_ptr_ack",  32'(a), 32'(0));
    write_byte(8'hA5, a); check_eq("w1_d0_ack",   32'(a), 32'(0));
    write_byte(8'h5A, a); check_eq("w1_d1_ack",   32'(a), 32'(0));
    check_eq("w1_busy", 32'(busy), 32'(1));
    i2c_stop();
    wait_q();
    check_eq("w1_wr_count", 32'(wr_log_addr.size()), 32'(2));
    if (wr_log_addr.size() == 2) begin
      check_eq("w1_wr0_addr", 32'(wr_log_addr[0]), 32'(3));
      check_eq("w1_wr0_data", 32'(wr_log_data[0]), 32'(8'hA5));
      check_eq("w1_wr1_addr", 32'(wr_log_addr[1]), 32'(4));
      check_eq("w1_wr1_data", 32'(wr_log_data[1]), 32'(8'h5A));
    end
    check_eq("w1_ptr", 32'(ptr), 32'(5));
    check_eq("w1_busy_after_stop", 32'(busy), 32'(0));
    $display("txn write1: ptr 0x03 <- A5 5A, ptr now %0d", ptr);

    // 2: read back both bytes
    clear_logs();
    read_at("r1", 8'h03, 2);
    check_eq("r1_byte0", 32'(rd_buf[0]), 32'(8'hA5));
    check_eq("r1_byte1", 32'(rd_buf[1]), 32'(8'h5A));
    check_eq("r1_ptr",   32'(ptr), 32'(5));
    check_eq("r1_no_wr", 32'(wr_log_addr.size()), 32'(0));

    // 3: address mismatch (0x51)
    clear_logs();
    i2c_start();
    write_byte(8'hA2, a); check_eq("mm_addr_nack", 32'(a), 32'(1));
    write_byte(8'h3C, a); check_eq("mm_data_nack", 32'(a), 32'(1));
    i2c_stop();
    wait_q();
    check_eq("mm_sda_never_driven", 32'(dut_drove), 32'(0));
    check_eq("mm_no_wr", 32'(wr_log_addr.size()), 32'(0));
    check_eq("mm_busy_never", 32'(busy_seen), 32'(0));
    check_eq("mm_ptr", 32'(ptr), 32'(5));
    $display("txn mismatch: addr 0x51 ignored");

    // 4: pointer wrap
    clear_logs();
    i2c_start();
    write_byte(8'hA0, a); check_eq("wr_addr_ack", 32'(a), 32'(0));
    write_byte(8'h0F, a); check_eq("wr_ptr_ack",  32'(a), 32'(0));
    write_byte(8'h11, a); check_eq("wr_d0_ack",   32'(a), 32'(0));
    write_byte(8'h22, a); check_eq("wr_d1_ack",   32'(a), 32'(0));
    i2c_stop();
    wait_q();
    check_eq("wrap_wr_count", 32'(wr_log_addr.size()), 32'(2));
    if (wr_log_addr.size() == 2) begin
      check_eq("wrap_wr0_addr", 32'(wr_log_addr[0]), 32'(15));
      check_eq("wrap_wr1_addr", 32'(wr_log_addr[1]), 32'(0));
    end
    check_eq("wrap_ptr", 32'(ptr), 32'(1));
    $display("txn wrap: ptr 0x0F <- 11 22, ptr now %0d", ptr);
    read_at("wrap_rd", 8'h0F, 2);
    check_eq("wrap_mem15", 32'(rd_buf[0]), 32'(8'h11));
    check_eq("wrap_mem0",  32'(rd_buf[1]), 32'(8'h22));
    check_eq("wrap_rd_ptr", 32'(ptr), 32'(1));

    // 5: reset during bit 4 of a data byte
    clear_logs();
    i2c_start();
    write_byte(8'hA0, a); check_eq("rs_addr_ack", 32'(a), 32'(0));
    write_byte(8'h06, a); check_eq("rs_ptr_ack",  32'(a), 32'(0));
    put_bit(1'b1); put_bit(1'b1); put_bit(1'b1);
    m_sda_low = 1'b0; wait_q();
    m_scl = 1'b1;     wait_q();
    check_eq("rs_busy_before", 32'(busy), 32'(1));
    rst = 1'b1;
    #1;
    check_eq("rs_busy",    32'(busy), 32'(0));
    check_eq("rs_sda_z",   32'(SDA === 1'b1), 32'(1));
    check_eq("rs_ptr",     32'(ptr), 32'(0));
    check_eq("rs_wr_en",   32'(wr_en), 32'(0));
    check_eq("rs_wr_addr", 32'(wr_addr), 32'(0));
    check_eq("rs_wr_data", 32'(wr_data), 32'(0));
    $display("txn reset: asserted mid-byte");
    wait_q();
    m_scl = 1'b0; wait_q();
    rst = 1'b0;   wait_q();
    i2c_stop();
    wait_q();
    clear_logs();
    i2c_start();
    write_byte(8'hA0, a); check_eq("rs2_addr_ack", 32'(a), 32'(0));
    write_byte(8'h00, a); check_eq("rs2_ptr_ack",  32'(a), 32'(0));
    write_byte(8'h77, a); check_eq("rs2_d0_ack",   32'(a), 32'(0));
    i2c_stop();
    wait_q();
    check_eq("rs2_wr_count", 32'(wr_log_addr.size()), 32'(1));
    if (wr_log_addr.size() == 1) begin
      check_eq("rs2_wr_addr", 32'(wr_log_addr[0]), 32'(0));
      check_eq("rs2_wr_data", 32'(wr_log_data[0]), 32'(8'h77));
    end
    check_eq("rs2_ptr", 32'(ptr), 32'(1));
    $display("txn write-after-reset: ptr 0x00 <- 77, ptr now %0d", ptr);
    read_at("rs_mem", 8'h03, 1);
    check_eq("rs_mem3_cleared", 32'(rd_buf[0]), 32'(8'h00));

    // 6: STOP after 3 data bits
    clear_logs();
    i2c_start();
    write_byte(8'hA0, a); check_eq("ms_addr_ack", 32'(a), 32'(0));
    write_byte(8'h08, a); check_eq("ms_ptr_ack",  32'(a), 32'(0));
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
    i2c_stop();
    wait_q();
    check_eq("ms_no_wr", 32'(wr_log_addr.size()), 32'(0));
    check_eq("ms_busy",  32'(busy), 32'(0));
    check_eq("ms_ptr",   32'(ptr), 32'(8));
    $display("txn mid-stop: STOP after 3 data bits, ptr %0d", ptr);
    read_at("ms_rd", 8'h08, 1);
    check_eq("ms_mem8_unchanged", 32'(rd_buf[0]), 32'(8'h00));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
